fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 123 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Turns a standard (one-cycle read latency) FIFO read port into a valid/ready
// stream with packet framing. A two-entry skid buffer absorbs the word that is
// already in flight when the consumer stalls. Because of this buffer the
// consumer sees registered outputs and the block still moves one word per cycle.
module fifo_rd_stream #(
  parameter int DWIDTH  = 32,
  parameter int PKT_LEN = 4
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              RD_EN,
  input  logic [DWIDTH-1:0] DOUT,
  input  logic              EMPTY,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DWIDTH-1:0] M_DATA,
  output logic              M_LAST
);

  // Beat counter width; a 1-word packet still gets a 1-bit counter pinned at 0.
  localparam int            BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

  // Control state (reset) and buffer data (no reset: contents are qualified by cnt_q).
  logic [1:0]        cnt_q,   cnt_d;
  logic              infl_q,  infl_d;
  logic [BW-1:0]     beat_q,  beat_d;
  logic              valid_q, valid_d;
  logic              last_q,  last_d;
  logic [DWIDTH-1:0] head_q,  head_d;
  logic [DWIDTH-1:0] tail_q,  tail_d;

  logic              pop_s;
  logic [2:0]        occ_s;
  logic              rd_en_s;

  // Read request: issue only if the buffer has room for the word once the
  // pending capture and this cycle's transfer are accounted for.
  always_comb begin
    pop_s   = valid_q & M_READY;
    occ_s   = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop_s};
    rd_en_s = RST & ~EMPTY & (occ_s < 3'd2);
  end

  // Buffer next state: capture the in-flight word at the tail and shift on transfer.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({infl_q, pop_s})
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = DOUT;
        end else begin
          tail_d = DOUT;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = DOUT;
        end else begin
          head_d = tail_q;
          tail_d = DOUT;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Framing and flag next state: beat advances on every transfer and wraps at packet end.
  always_comb begin
    infl_d = rd_en_s;
    if (pop_s) begin
      if (beat_q == LAST_BEAT) begin
        beat_d = '0;
      end else begin
        beat_d = beat_q + BEAT_ONE;
      end
    end else begin
      beat_d = beat_q;
    end
    valid_d = (cnt_d != 2'd0);
    last_d  = valid_d & (beat_d == LAST_BEAT);
  end

  // Control registers; cleared immediately whenever reset is held low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q   <= 2'd0;
      infl_q  <= 1'b0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      infl_q  <= infl_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Buffer data registers; no reset because valid_q qualifies their contents.
  always_ff @(posedge CLK) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign RD_EN   = rd_en_s;
  assign M_VALID = valid_q;
  assign M_DATA  = head_q;
  assign M_LAST  = last_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: an upstream FIFO model, a transaction-level output
// model (a queue of buffered words plus a transfer count), an in-order
// scoreboard and directed scenarios. Two instances share the stimulus: one
// uses 4-word packets and the other uses 3-word packets.
module tb_fifo_rd_stream;
  localparam int DW = 32;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          empty   = 1'b1;
  logic          m_ready = 1'b0;
  logic [DW-1:0] dout    = '0;
  logic          rd4, rd3, v4, v3, l4, l3;
  logic [DW-1:0] d4, d3;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DWIDTH(DW), .PKT_LEN(4)) dut4 (
    .CLK(clk), .RST(rst), .RD_EN(rd4), .DOUT(dout), .EMPTY(empty),
    .M_VALID(v4), .M_READY(m_ready), .M_DATA(d4), .M_LAST(l4));

  fifo_rd_stream #(.DWIDTH(DW), .PKT_LEN(3)) dut3 (
    .CLK(clk), .RST(rst), .RD_EN(rd3), .DOUT(dout), .EMPTY(empty),
    .M_VALID(v3), .M_READY(m_ready), .M_DATA(d3), .M_LAST(l3));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DW-1:0] fifo_q[$];  // upstream FIFO contents
  logic [DW-1:0] exp_q[$];   // words that must come out, in order
  logic [DW-1:0] buf_m[$];   // model: words held by the block
  bit            infl_m, rd_prev, pop_prev;
  int            pops_m;     // model: transfers since reset

  int rd_cnt, val_cnt, deliv_cnt, first_rd, last_rd, first_val, last_val;
  int last4_cnt, last3_cnt, bad_rd;
  logic [DW-1:0] last4_word;
  logic [DW-1:0] last3_words[$];
  bit            stall_prev;
  logic [DW-1:0] d_prev;
  logic          l_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic clr_stats();
    rd_cnt = 0; val_cnt = 0; deliv_cnt = 0; first_rd = -1; last_rd = -1;
    first_val = -1; last_val = -1; last4_cnt = 0; last3_cnt = 0; bad_rd = 0;
    last4_word = '0;
    last3_words.delete();
  endtask

  task automatic clr_model();
    fifo_q.delete(); exp_q.delete(); buf_m.delete();
    infl_m = 1'b0; rd_prev = 1'b0; pop_prev = 1'b0; pops_m = 0; stall_prev = 1'b0;
  endtask

  // One clock cycle: advance the model over the rising edge that just passed,
  // compare registered outputs, drive new inputs, then check the read request.
  task automatic step(input bit rdy);
    bit            exp_v, exp_rd, pop_now;
    int            occ;
    logic [DW-1:0] w;
    @(negedge clk);
    cyc++;
    if (rst) begin
      if (pop_prev && buf_m.size() > 0) begin
        void'(buf_m.pop_front());
        pops_m++;
      end
      if (infl_m) buf_m.push_back(dout);
      infl_m = rd_prev;
    end
    exp_v = (buf_m.size() != 0);
    check("m_valid4", v4, exp_v);
    check("m_valid3", v3, exp_v);
    check("m_last4", l4, exp_v && (pops_m % 4 == 3));
    check("m_last3", l3, exp_v && (pops_m % 3 == 2));
    if (exp_v) begin
      check("m_data4", d4, buf_m[0]);
      check("m_data3", d3, buf_m[0]);
    end
    if (stall_prev) begin
      check("stall_data_stable", d4, d_prev);
      check("stall_last_stable", l4, l_prev);
    end
    if (rd_prev && fifo_q.size() > 0) dout = fifo_q.pop_front();
    else                              dout = 32'hDEAD_0000 | 32'(cyc);
    empty   = (fifo_q.size() == 0);
    m_ready = rdy;
    #1;
    pop_now = exp_v && rdy;
    occ     = buf_m.size() + int'(infl_m) - int'(pop_now);
    exp_rd  = rst && !empty && (occ < 2);
    check("rd_en4", rd4, exp_rd);
    check("rd_en3", rd3, exp_rd);
    if (rd4 && (buf_m.size() + int'(infl_m) == 2) && !pop_now) bad_rd++;
    if (rd4) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (v4) begin
      val_cnt++;
      if (first_val < 0) first_val = cyc;
      last_val = cyc;
    end
    if (v4 && rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_order: got %0h expected no word (cycle %0d)", d4, cyc);
      end else begin
        w = exp_q.pop_front();
        if (d4 !== w) begin
          errors++;
          $display("FAIL out_order: got %0h expected %0h (cycle %0d)", d4, w, cyc);
        end
      end
      deliv_cnt++;
      if (l4) begin last4_cnt++; last4_word = d4; end
      if (l3) last3_words.push_back(d3);
      if (l3) last3_cnt++;
    end
    stall_prev = v4 && !rdy;
    d_prev     = d4;
    l_prev     = l4;
    rd_prev    = rd4 && !empty;
    pop_prev   = pop_now;
  endtask

  // Assert reset part-way through a cycle and check the outputs drop at once.
  task automatic do_reset(input int hold);
    #2;
    rst = 1'b0;
    #1;
    check("rst_m_valid4", v4, 1'b0);
    check("rst_m_last4", l4, 1'b0);
    check("rst_rd_en4", rd4, 1'b0);
    check("rst_m_valid3", v3, 1'b0);
    check("rst_m_last3", l3, 1'b0);
    clr_model();
    repeat (hold) step(1'b1);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit reached;
    clr_model();
    clr_stats();
    // Reset with a non-empty FIFO flag and a ready consumer: nothing may be requested.
    empty = 1'b0; m_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("init_rd_en", rd4, 1'b0);
    check("init_m_valid", v4, 1'b0);
    check("init_m_last", l4, 1'b0);
    empty = 1'b1;
    repeat (3) step(1'b1);
    rst = 1'b1;
    repeat (2) step(1'b1);

    // Four words and a ready consumer: back-to-back reads, output two cycles later.
    clr_stats();
    for (int i = 0; i < 4; i++) push(32'(i));
    repeat (8) step(1'b1);
    check("s1_rd_count", rd_cnt, 4);
    check("s1_rd_span", last_rd - first_rd, 3);
    check("s1_valid_count", val_cnt, 4);
    check("s1_valid_start", first_val - first_rd, 2);
    check("s1_valid_span", last_val - first_val, 3);
    check("s1_delivered", deliv_cnt, 4);
    check("s1_last_count", last4_cnt, 1);
    check("s1_last_word", last4_word, 32'h3);

    // Eight words with the consumer toggling every cycle.
    clr_stats();
    for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
    for (int c = 0; c < 30; c++) step(c % 2 == 0);
    check("s2_delivered", deliv_cnt, 8);
    check("s2_bad_rd", bad_rd, 0);
    check("s2_left", exp_q.size(), 0);

    // Consumer stalled with five words available: the buffer fills and reads stop.
    clr_stats();
    for (int i = 0; i < 5; i++) push(32'h20 + 32'(i));
    repeat (10) step(1'b0);
    check("s3_rd_count", rd_cnt, 2);
    check("s3_model_cnt", buf_m.size(), 2);
    check("s3_fifo_left", fifo_q.size(), 3);
    check("s3_m_valid", v4, 1'b1);
    repeat (12) step(1'b1);
    check("s3_delivered", deliv_cnt, 5);

    // Three-word packets: seven words end packets on the third and sixth word.
    do_reset(2);
    clr_stats();
    for (int i = 0; i < 7; i++) push(32'h40 + 32'(i));
    repeat (14) step(1'b1);
    check("s4_delivered", deliv_cnt, 7);
    check("s4_last3_count", last3_cnt, 2);
    if (last3_words.size() == 2) begin
      check("s4_last3_first", last3_words[0], 32'h42);
      check("s4_last3_second", last3_words[1], 32'h45);
    end
    check("s4_beat3", pops_m % 3, 1);
    check("s4_last4_word", last4_word, 32'h43);

    // Reset while streaming, with a word buffered and another in flight.
    clr_stats();
    for (int i = 0; i < 6; i++) push(32'h60 + 32'(i));
    reached = 1'b0;
    for (int c = 0; c < 10 && !reached; c++) begin
      step(1'b1);
      if (buf_m.size() == 1 && infl_m && v4) reached = 1'b1;
    end
    check("s5_state_reached", reached, 1'b1);
    do_reset(2);
    clr_stats();
    repeat (4) step(1'b1);
    check("s5_no_stale", val_cnt, 0);
    push(32'h80); push(32'h81);
    repeat (8) step(1'b1);
    check("s5_delivered", deliv_cnt, 2);
    check("s5_left", exp_q.size(), 0);

    // A single word; the FIFO goes empty right after the read.
    clr_stats();
    push(32'hA5);
    repeat (8) step(1'b1);
    check("s6_rd_count", rd_cnt, 1);
    check("s6_delivered", deliv_cnt, 1);
    check("s6_valid_count", val_cnt, 1);
    check("s6_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
